mux41_rr_arbiter: RTL
=====================

# mux41_rr_arbiter

Round-robin arbiter that shares a single 4:1 one-bit selector datapath between four requesters. Each cycle it decides which requester owns the selector and drives the selector's 2-bit select from a registered grant, so the mux output always reflects exactly one granted source. It sits directly in front of the 4:1 mux, and its `sel` output feeds the mux select port.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold the grant while others wait. Range 1..255. Used only when `MUX41_ARB_HOLD_LIMIT_EN` is defined.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, 4: request vector; bit i = requester i wants the mux. Level-sensitive.
- `gnt`, output, 4: one-hot registered grant, or all zeros when idle.
- `sel`, output, 2: registered mux select, equal to the index of the set `gnt` bit. Holds its last value when idle.
- `busy`, output, 1: registered; high whenever `gnt` is nonzero.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: one owner.
- Reset state:
  - State is IDLE.
  - `gnt`=4'b0000, `sel`=2'd0, `busy`=0.
  - Round-robin pointer `last`=2'd3, so requester 0 has first priority after reset.
  - Hold counter is 0.
- Pick rule: search from index `last+1` upward, modulo 4. The first set `req` bit wins.
- IDLE:
  - If `req`≠0, pick a winner, go to GRANT, set `gnt`/`sel` to the winner, set `last` to the winner, clear the hold counter.
  - If `req`=0, stay in IDLE.
- GRANT, owner's `req` still high:
  - Keep the grant and increment the hold counter, saturating.
  - Preemption occurs only under the hold-limit rule (see Configuration).
- GRANT, owner's `req` low:
  - If other requests are pending, re-arbitrate in the same edge and grant the new winner with no idle cycle.
  - Otherwise go to IDLE: `gnt`=0, `busy`=0, `sel` unchanged.
- Simultaneous requests are resolved purely by the pointer. Example: with `last`=1, `req`=4'b1101 grants index 2, and with `last`=2 the same request grants index 3.
- A request that drops and reasserts while not granted loses no priority. Priority depends only on `last`.
- A requester may not lose a grant while its `req` is high unless hold-limit preemption fires.
- Reset asserted mid-grant: outputs return to their reset values immediately and asynchronously, and the pointer returns to 3.

## Timing
- Latency: `req` rising at edge N is reflected in `gnt`/`sel`/`busy` after edge N+1. All outputs are flops, with no combinational path from `req`.
- `sel` and `gnt` change on the same edge, so the mux output changes one cycle after the grant decision.
- Handover is zero-bubble: the old owner's `gnt` falls and the new owner's `gnt` rises on the same edge.
- Release latency: the owner dropping `req` before edge N loses `gnt` at edge N.

## Configuration
- Macro: `MUX41_ARB_HOLD_LIMIT_EN`.
- Defined:
  - The hold counter is built.
  - When the owner has held the grant for `MAX_HOLD` cycles and any other `req` bit is set, the next edge forcibly re-arbitrates with the owner excluded, then clears the counter.
  - If no other requester is waiting, the owner keeps the grant indefinitely and the counter saturates at `MAX_HOLD`.
- Undefined:
  - No counter is built and `MAX_HOLD` is ignored.
  - The owner keeps the grant until it drops `req`.

## Structure
- Package `mux41_arb_pkg` holds:
  - `N_REQ`=4 and `SEL_W`=2.
  - The state enum `arb_state_t` {ARB_IDLE, ARB_GRANT}.
  - A one-hot-to-index function.
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: `req`, `last`, and an exclude mask.
  - Outputs: a found flag, a 2-bit winner, and a one-hot winner.
  - It is instantiated once.

## Test plan
- Reset then single request:
  - Release `rst_n`, then `req`=4'b0100.
  - After one edge, `gnt`=4'b0100, `sel`=2, `busy`=1.
  - `gnt`=0, `sel`=0 throughout reset.
- Fairness:
  - Hold `req`=4'b1111 and have each owner drop its own `req` one cycle after it is granted.
  - Grants follow the order 0,1,2,3,0 with no idle cycle between owners.
- Release to idle:
  - Owner 3 drops `req` while `req`=0 elsewhere.
  - The next edge gives `gnt`=0, `busy`=0, `sel` holds 3.
  - A later `req`=4'b1001 grants 0, because the pointer wraps from 3.
- Hold limit, with macro defined and `MAX_HOLD`=4:
  - Owner 0 holds `req` while `req[2]`=1.
  - `gnt[0]` stays high for exactly 4 cycles, then `gnt`=4'b0100.
  - Without the macro, `gnt[0]` stays high for as long as `req[0]` is held.
- Async reset mid-grant:
  - Pull `rst_n` low between edges while `gnt`=4'b0010.
  - Outputs clear without waiting for a clock edge.
  - After release, `req`=4'b0011 grants 0.

Source files
------------

// File: rtl/mux41_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux41_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (oh[i]) oh2idx = SEL_W'(i);
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_pick.sv
// Combinational round-robin picker: first candidate strictly after 'last', wrapping.
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] win,
  output logic [N_REQ-1:0] win_oh
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    cand   = req & ~excl;
    win_oh = '0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (cand[idx]) begin
        win_oh      = '0;
        win_oh[idx] = 1'b1;
      end
    end
    found = |cand;
    win   = oh2idx(win_oh);
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux select; all outputs registered.
// Optional hold-limit preemption: define MUX41_ARB_HOLD_LIMIT_EN.
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 1..255");
  end

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n, excl, win_oh;
  logic [SEL_W-1:0] sel_n, last, last_n, win;
  logic             busy_n, found, own_req, preempt;

  assign own_req = |(req & gnt);

`ifdef MUX41_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt, hold_n;

  // hold_cnt counts edges kept after the granting edge, so cnt+1 cycles held.
  assign preempt = (state == ARB_GRANT) && own_req &&
                   (hold_cnt >= 8'(MAX_HOLD - 1)) && |(req & ~gnt);
  assign excl    = preempt ? gnt : '0;

  always_comb begin
    hold_n = '0;
    if (state == ARB_GRANT && own_req && !preempt)
      hold_n = (hold_cnt >= 8'(MAX_HOLD)) ? hold_cnt : hold_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_n;
`else
  assign preempt = 1'b0;
  assign excl    = '0;
`endif

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .excl   (excl),
    .found  (found),
    .win    (win),
    .win_oh (win_oh)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    last_n  = last;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_n = ARB_GRANT;
          gnt_n   = win_oh;
          sel_n   = win;
          last_n  = win;
        end
      end
      ARB_GRANT: begin
        if (own_req && !preempt) begin
          gnt_n = gnt;
        end else if (found) begin
          gnt_n  = win_oh;
          sel_n  = win;
          last_n = win;
        end else begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
    busy_n = |gnt_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= SEL_W'(N_REQ - 1);
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      last  <= last_n;
      busy  <= busy_n;
    end
  end

endmodule
